// File: rtl/blood_sprite_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module : blood_sprite_renderer_pkg
// Brief  : Shared constants and FSM encodings for the blood-splatter renderer.
// Rev    : 1.0
// ============================================================================
package blood_sprite_renderer_pkg;

    localparam int          c_SPR_SIZE    = 64;
    localparam int          c_SCREEN_W    = 640;
    localparam int          c_SCREEN_H    = 480;
    localparam logic [11:0] c_TRANSP_DEF  = 12'h000;

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ARMED = 2'd1;
    localparam logic [1:0]  c_ST_SHOW  = 2'd2;

endpackage : blood_sprite_renderer_pkg
`default_nettype wire

// File: rtl/blood_life_timer.sv
`default_nettype none
// ============================================================================
// Module : blood_life_timer
// Brief  : Loadable frame down-counter; flags the tick that ends the lifetime.
// Rev    : 1.0
// ============================================================================
module blood_life_timer #(
    parameter int LIFE_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expire
);
    localparam int c_W = $clog2(LIFE_FRAMES + 1);

    logic [c_W-1:0] r_life;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_life <= '0;
        end else if (i_load) begin
            r_life <= c_W'(LIFE_FRAMES);
        end else if (i_tick && (r_life != '0)) begin
            r_life <= r_life - c_W'(1);
        end
    end

    assign o_expire = i_tick & (r_life == c_W'(1));

endmodule : blood_life_timer
`default_nettype wire

// File: rtl/blood_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module : blood_sprite_renderer
// Brief  : Positions a 64x64 splatter sprite and composites it over video.
// Rev    : 1.0
// ============================================================================
module blood_sprite_renderer
    import blood_sprite_renderer_pkg::*;
#(
    parameter int          LIFE_FRAMES = 30,
    parameter logic [11:0] TRANSPARENT = c_TRANSP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        trigger,
    input  logic [9:0]  trig_x,
    input  logic [9:0]  trig_y,
    input  logic [11:0] pixel_in,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [11:0] pixel_out,
    output logic        active,
    output logic        done
);
    logic [1:0]  r_state;
    logic        r_from_show;
    logic [9:0]  r_pend_x, r_pend_y;
    logic [9:0]  r_pos_x, r_pos_y;
    logic        r_done;
    logic [5:0]  r_rom_row, r_rom_col;
    logic        r_in_win_d, r_vo_d;
    logic [11:0] r_pix_d, r_pixel_out;

    logic        w_promote, w_tick, w_expire, w_active, w_in_win;
    logic [9:0]  w_new_x, w_new_y;
    logic [10:0] w_x_end, w_y_end;

    // A trigger coinciding with frame_tick is promoted straight to SHOW.
    assign w_promote = frame_tick & (trigger | (r_state == c_ST_ARMED));
    assign w_tick    = frame_tick & ~trigger & (r_state == c_ST_SHOW);
    assign w_new_x   = trigger ? trig_x : r_pend_x;
    assign w_new_y   = trigger ? trig_y : r_pend_y;
    assign w_active  = (r_state == c_ST_SHOW) |
                       ((r_state == c_ST_ARMED) & r_from_show);

    blood_life_timer #(
        .LIFE_FRAMES (LIFE_FRAMES)
    ) u_life (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_promote),
        .i_tick   (w_tick),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_from_show <= 1'b0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_expire;
            if (trigger) begin
                r_pend_x <= trig_x;
                r_pend_y <= trig_y;
            end
            if (w_promote) begin
                r_state     <= c_ST_SHOW;
                r_from_show <= 1'b0;
                r_pos_x     <= w_new_x;
                r_pos_y     <= w_new_y;
            end else if (trigger) begin
                r_state     <= c_ST_ARMED;
                r_from_show <= w_active;
            end else if (w_expire) begin
                r_state     <= c_ST_IDLE;
                r_from_show <= 1'b0;
            end
        end
    end

    // 11-bit window bounds so a sprite near the right/bottom edge never wraps.
    assign w_x_end  = {1'b0, r_pos_x} + 11'(c_SPR_SIZE);
    assign w_y_end  = {1'b0, r_pos_y} + 11'(c_SPR_SIZE);
    assign w_in_win = w_active & video_on &
                      ({1'b0, x} >= {1'b0, r_pos_x}) & ({1'b0, x} < w_x_end) &
                      ({1'b0, y} >= {1'b0, r_pos_y}) & ({1'b0, y} < w_y_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_row   <= '0;
            r_rom_col   <= '0;
            r_in_win_d  <= 1'b0;
            r_vo_d      <= 1'b0;
            r_pix_d     <= '0;
            r_pixel_out <= '0;
        end else begin
            r_rom_row  <= w_in_win ? (y[5:0] - r_pos_y[5:0]) : 6'd0;
            r_rom_col  <= w_in_win ? (x[5:0] - r_pos_x[5:0]) : 6'd0;
            r_in_win_d <= w_in_win;
            r_vo_d     <= video_on;
            r_pix_d    <= pixel_in;
            if (!r_vo_d) begin
                r_pixel_out <= '0;
            end else if (r_in_win_d && (rom_data != TRANSPARENT)) begin
                r_pixel_out <= rom_data;
            end else begin
                r_pixel_out <= r_pix_d;
            end
        end
    end

    assign rom_row   = r_rom_row;
    assign rom_col   = r_rom_col;
    assign pixel_out = r_pixel_out;
    assign active    = w_active;
    assign done      = r_done;

endmodule : blood_sprite_renderer
`default_nettype wire

// File: tb/tb_blood_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module : tb_blood_sprite_renderer
// Brief  : Directed self-checking bench for blood_sprite_renderer.
// Rev    : 1.0
// ============================================================================
module tb_blood_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset, video_on, frame_tick, trigger;
    logic [9:0]  x, y, trig_x, trig_y;
    logic [11:0] pixel_in, rom_data, pixel_out;
    logic [5:0]  rom_row, rom_col;
    logic        active, done;
    logic [11:0] spot_val, fill_val;
    int          checks = 0;
    int          errors = 0;
    int          ndone  = 0;

    always #5 clk = ~clk;

    blood_sprite_renderer #(
        .LIFE_FRAMES (3),
        .TRANSPARENT (12'h000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .trigger    (trigger),
        .trig_x     (trig_x),
        .trig_y     (trig_y),
        .pixel_in   (pixel_in),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .pixel_out  (pixel_out),
        .active     (active),
        .done       (done)
    );

    // Sprite ROM model: one marked texel at row 3 col 5, uniform fill elsewhere.
    always_comb rom_data = ((rom_row == 6'd3) && (rom_col == 6'd5)) ? spot_val : fill_val;

    always @(negedge clk) if (done) ndone++;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py,
                       input logic vo, input logic [11:0] pin);
        x = px; y = py; video_on = vo; pixel_in = pin;
        cyc();
        cyc();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic trig(input logic [9:0] tx, input logic [9:0] ty, input logic with_tick);
        trigger = 1'b1; trig_x = tx; trig_y = ty; frame_tick = with_tick;
        cyc();
        trigger = 1'b0; frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; frame_tick = 1'b0; trigger = 1'b0;
        x = '0; y = '0; trig_x = '0; trig_y = '0; pixel_in = 12'hFFF;
        spot_val = 12'hE00; fill_val = 12'h0A0;
        cyc(); cyc();
        chk("rst_pixel_out", pixel_out, 12'h000);
        chk("rst_rom_row", 12'(rom_row), 12'h000);
        chk("rst_rom_col", 12'(rom_col), 12'h000);
        chk1("rst_active", active, 1'b0);
        chk1("rst_done", done, 1'b0);
        reset = 1'b0;

        // Basic hit at (100,50)
        trig(10'd100, 10'd50, 1'b0);
        chk1("armed_inactive", active, 1'b0);
        pix(10'd105, 10'd53, 1'b1, 12'h111);
        chk("armed_no_draw", pixel_out, 12'h111);
        tick();
        chk1("show_active", active, 1'b1);
        pix(10'd105, 10'd53, 1'b1, 12'h111);
        chk("spot_pixel", pixel_out, 12'hE00);
        chk("spot_row", 12'(rom_row), 12'd3);
        chk("spot_col", 12'(rom_col), 12'd5);
        pix(10'd99, 10'd53, 1'b1, 12'h111);
        chk("left_of_win", pixel_out, 12'h111);
        chk("outside_row0", 12'(rom_row), 12'd0);
        pix(10'd164, 10'd53, 1'b1, 12'h111);
        chk("right_of_win", pixel_out, 12'h111);
        pix(10'd163, 10'd53, 1'b1, 12'h111);
        chk("right_edge_in", pixel_out, 12'h0A0);
        pix(10'd105, 10'd49, 1'b1, 12'h111);
        chk("above_win", pixel_out, 12'h111);

        // Transparency and blanking
        spot_val = 12'h000; fill_val = 12'h000;
        pix(10'd105, 10'd53, 1'b1, 12'h222);
        chk("transparent", pixel_out, 12'h222);
        pix(10'd105, 10'd53, 1'b0, 12'h222);
        chk("blanking", pixel_out, 12'h000);
        spot_val = 12'hE00; fill_val = 12'h0A0;

        // Retrigger mid-frame while shown
        trig(10'd300, 10'd200, 1'b0);
        chk1("retrig_active", active, 1'b1);
        pix(10'd105, 10'd53, 1'b1, 12'h333);
        chk("retrig_old_pos", pixel_out, 12'hE00);
        pix(10'd305, 10'd203, 1'b1, 12'h333);
        chk("retrig_new_pending", pixel_out, 12'h333);
        tick();
        pix(10'd305, 10'd203, 1'b1, 12'h333);
        chk("retrig_new_pos", pixel_out, 12'hE00);
        pix(10'd105, 10'd53, 1'b1, 12'h333);
        chk("retrig_old_gone", pixel_out, 12'h333);
        chk("retrig_no_done", 12'(ndone), 12'd0);

        // Lifetime of 3 frames after the promoting tick
        tick();
        chk1("life_t2_active", active, 1'b1);
        chk1("life_t2_done", done, 1'b0);
        tick();
        chk1("life_t3_active", active, 1'b1);
        chk1("life_t3_done", done, 1'b0);
        tick();
        chk1("life_t4_done", done, 1'b1);
        chk1("life_t4_active", active, 1'b0);
        cyc();
        chk1("done_one_cycle", done, 1'b0);
        chk("done_count", 12'(ndone), 12'd1);
        pix(10'd305, 10'd203, 1'b1, 12'h444);
        chk("expired_no_draw", pixel_out, 12'h444);

        // Simultaneous trigger/tick at the screen corner
        trig(10'd600, 10'd460, 1'b1);
        chk1("simul_active", active, 1'b1);
        pix(10'd603, 10'd465, 1'b1, 12'h444);
        chk("corner_fill", pixel_out, 12'h0A0);
        pix(10'd605, 10'd463, 1'b1, 12'h444);
        chk("corner_spot", pixel_out, 12'hE00);
        pix(10'd639, 10'd479, 1'b1, 12'h444);
        chk("corner_last", pixel_out, 12'h0A0);
        pix(10'd10, 10'd10, 1'b1, 12'h555);
        chk("no_wrap_a", pixel_out, 12'h555);
        pix(10'd39, 10'd19, 1'b1, 12'h555);
        chk("no_wrap_b", pixel_out, 12'h555);
        pix(10'd600, 10'd459, 1'b1, 12'h555);
        chk("above_corner", pixel_out, 12'h555);
        chk("simul_no_done", 12'(ndone), 12'd1);

        // Reset held mid-SHOW
        x = 10'd605; y = 10'd463; video_on = 1'b1; pixel_in = 12'h5A5;
        reset = 1'b1;
        cyc(); cyc(); cyc();
        chk("midrst_pixel_out", pixel_out, 12'h000);
        chk1("midrst_active", active, 1'b0);
        chk1("midrst_done", done, 1'b0);
        reset = 1'b0;
        cyc();
        chk("post_rst_lag1", pixel_out, 12'h000);
        cyc();
        chk("post_rst_lag2", pixel_out, 12'h5A5);
        chk1("post_rst_active", active, 1'b0);
        chk("midrst_no_done", 12'(ndone), 12'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_blood_sprite_renderer
`default_nettype wire
